requant_int20_to_int12: RTL and testbench
=========================================

REQUANT_INT20_TO_INT12 -- requirements
Module: requant_int20_to_int12

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the saturation event counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream int20 accumulator word valid.
REQ-005 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-006 SHALL have port in20  input  20  signed accumulator value.
REQ-007 SHALL have port shift  input  4  right-shift amount, sampled with the in20 handshake.
REQ-008 SHALL have port out_valid  output  1  out12 holds a result.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-010 SHALL have port out12  output  12  signed requantized int12 result.
REQ-011 SHALL have port sat_clr  input  1  synchronous clear of sat_count.
REQ-012 SHALL have port sat_count  output  CNT_W  number of saturated results.

Function
REQ-013 SHALL transfer an input word when in_valid && in_ready, and an output word when out_valid && out_ready.
REQ-014 SHALL be a two-stage pipeline: S1 registers the rounded, shifted value; S2 registers the saturated int12 result driving out12/out_valid.
REQ-015 SHALL advance S2 when !out_valid || out_ready; SHALL advance S1 when S1 is empty or S2 advances; in_ready SHALL equal the S1 advance condition.
REQ-016 SHALL have latency 2 cycles from input handshake to out_valid with out_ready held high, and sustain one word per cycle.
REQ-017 SHALL hold out12 and out_valid stable while out_valid && !out_ready.
REQ-018 SHALL clamp shift values above 11 to 11.
REQ-019 SHALL compute in S1, in 21-bit signed arithmetic: (in20 + (s>0 ? 2^(s-1) : 0)) >>> s (round half toward +infinity, arithmetic shift).
REQ-020 SHALL saturate the S1 value to [-2048, 2047] when loading S2; values in range pass unchanged.
REQ-021 SHALL increment sat_count by 1 on each S1-to-S2 transfer where saturation changed the value; sat_count SHALL stick at 2^CNT_W-1 and not wrap.
REQ-022 SHALL clear sat_count to 0 on sat_clr; sat_clr SHALL win over a simultaneous increment.
REQ-023 SHALL not drop, duplicate or reorder words under any in_valid/out_ready pattern.
REQ-024 SHALL have no combinational path from in_valid or in20 to any output.

Reset
REQ-025 SHALL on rst_n low immediately set out_valid=0, out12=0, sat_count=0, S1 empty, and in_ready low until reset is released.
REQ-026 SHALL discard in-flight S1/S2 words on reset mid-operation; the first cycle after release SHALL show in_ready=1, out_valid=0.

Configuration
REQ-027 With REQUANT_RELU_EN defined, SHALL force any negative S1 value to 0 before saturation; this SHALL not count as saturation, and out12 SHALL never be negative.
REQ-028 Without REQUANT_RELU_EN, SHALL pass negative values through the signed saturation of REQ-020.

Verification
REQ-029 in20=296, shift=4, out_ready=1 -> out12=19 exactly 2 cycles later, sat_count=0.
REQ-030 in20=-24, shift=4 -> out12=-1 (without REQUANT_RELU_EN); out12=0, sat_count=0 (with REQUANT_RELU_EN).
REQ-031 in20=0x7FFFF, shift=0, then in20=0x80000, shift=0 -> out12=2047 then -2048, sat_count=2 (1 with REQUANT_RELU_EN, second out12=0).
REQ-032 Stream of 8 words with out_ready low for cycles 3-6 -> in_ready drops after S1/S2 fill, all 8 results emitted in order, out12 stable while stalled.
REQ-033 CNT_W=4, 20 saturating words -> sat_count sticks at 15; sat_clr asserted in the same cycle as a saturating transfer -> sat_count=0.
REQ-034 rst_n pulsed low with 2 words in flight -> out_valid=0 immediately, no stale word emitted after release, next input processed normally.

Source files
------------

// File: rtl/requant_int20_to_int12.sv
// Two-stage int20 -> int12 requantizer: round-half-up arithmetic right shift, then saturate.
// Define REQUANT_RELU_EN to zero negative values before saturation.
module requant_int20_to_int12 #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [19:0]      in20,
   input  logic [3:0]       shift,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [11:0]      out12,
   input  logic             sat_clr,
   output logic [CNT_W-1:0] sat_count
);

   logic               s1_valid;
   logic signed [20:0] s1_val;
   logic               s1_adv;
   logic               s2_adv;
   logic [3:0]         shift_c;
   logic signed [20:0] rnd;
   logic signed [20:0] sum;
   logic signed [20:0] shifted;
   logic signed [20:0] pre;
   logic [11:0]        sat_val;
   logic               sat_hit;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   // Held low while reset is asserted; otherwise purely the S1 advance condition.
   assign in_ready = rst_n && s1_adv;

   always_comb begin
      shift_c = (shift > 4'd11) ? 4'd11 : shift;
      rnd     = '0;
      if (shift_c != 4'd0)
         rnd = 21'sd1 <<< (shift_c - 4'd1);
      sum     = $signed({in20[19], in20}) + rnd;
      shifted = sum >>> shift_c;
   end

   always_comb begin
      pre = s1_val;
`ifdef REQUANT_RELU_EN
      if (s1_val < 0)
         pre = '0;
`endif
      sat_hit = 1'b1;
      if (pre > 21'sd2047)
         sat_val = 12'h7ff;
      else if (pre < -21'sd2048)
         sat_val = 12'h800;
      else begin
         sat_val = pre[11:0];
         sat_hit = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_val   <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid)
            s1_val <= shifted;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out12     <= '0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid)
            out12 <= sat_val;
      end
   end

   // Clear has priority; the count sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sat_count <= '0;
      else if (sat_clr)
         sat_count <= '0;
      else if (s2_adv && s1_valid && sat_hit && (sat_count != {CNT_W{1'b1}}))
         sat_count <= sat_count + 1'b1;
   end

endmodule

// File: tb/tb_requant_int20_to_int12.sv
// Randomized bench for requant_int20_to_int12 against an integer-arithmetic reference model.
module tb_requant_int20_to_int12;
   localparam int CNT_W = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [19:0]      in20 = '0;
   logic [3:0]       shift = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [11:0]      out12;
   logic             sat_clr = 1'b0;
   logic [CNT_W-1:0] sat_count;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int model_cnt = 0;
   logic held_v = 1'b0;
   int held_val = 0;

   requant_int20_to_int12 #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in20(in20), .shift(shift), .out_valid(out_valid), .out_ready(out_ready),
      .out12(out12), .sat_clr(sat_clr), .sat_count(sat_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", tag, act, exp);
      end
   endtask

   // Reference: floor((x + half) / 2^s), then optional relu, then clamp to int12.
   task automatic model(input int x, input int s, output int r, output bit sat);
      int sc, d, v;
      sc = (s > 11) ? 11 : s;
      d  = 1 << sc;
      v  = x + ((sc > 0) ? d / 2 : 0);
      r  = (v >= 0) ? v / d : -((-v + d - 1) / d);
`ifdef REQUANT_RELU_EN
      if (r < 0) r = 0;
`endif
      sat = 1'b0;
      if (r > 2047) begin r = 2047; sat = 1'b1; end
      else if (r < -2048) begin r = -2048; sat = 1'b1; end
   endtask

   // Mid-cycle monitor: handshakes seen here complete on the next rising edge.
   always @(negedge clk) begin
      int r;
      bit sat;
      if (rst_n) begin
         if (held_v && out_valid) chk("hold", $signed(out12), held_val);
         held_v   = out_valid && !out_ready;
         held_val = $signed(out12);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("extra_word", 1, 0);
            else chk("out12", $signed(out12), exp_q.pop_front());
         end
         if (in_valid && in_ready) begin
            model($signed(in20), int'(shift), r, sat);
            exp_q.push_back(r);
            if (sat && model_cnt < CNT_MAX) model_cnt++;
         end
      end else
         held_v = 1'b0;
   end

   task automatic send(input logic [19:0] x, input logic [3:0] s);
      int n = 0;
      in_valid = 1'b1; in20 = x; shift = s;
      @(negedge clk);
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      if (!in_ready) chk("send_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      in_valid = 1'b0; out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 30) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      chk("drain", exp_q.size(), 0);
      chk("out_valid_idle", out_valid, 0);
   endtask

   initial begin
      #3;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out12", out12, 0);
      chk("rst_sat_count", sat_count, 0);
      chk("rst_in_ready", in_ready, 0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      #1 chk("rel_in_ready", in_ready, 1);
      @(posedge clk); #1;

      // Latency: 296 >> 4 rounds to 19, visible two edges after acceptance.
      out_ready = 1'b1;
      send(20'd296, 4'd4);
      chk("lat_s1_only", out_valid, 0);
      @(posedge clk); #1;
      chk("lat_valid", out_valid, 1);
      chk("lat_val", $signed(out12), 19);
      chk("lat_sat", sat_count, 0);
      drain();

      send(-20'sd24, 4'd4);
      send(20'h7FFFF, 4'd0);
      send(20'h80000, 4'd0);
      send(20'd1000, 4'd15);
      drain();
      chk("sat_two", sat_count, model_cnt);

      // Backpressure: S2 and S1 fill, then in_ready must drop.
      out_ready = 1'b0;
      send(20'd100, 4'd1);
      send(20'd200, 4'd2);
      in_valid = 1'b1; in20 = 20'd300; shift = 4'd3;
      @(negedge clk);
      chk("full_in_ready", in_ready, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(20'd300, 4'd3);
      for (int i = 0; i < 5; i++) send(20'(i * 777), 4'(i));
      drain();

      // Sticky counter at 15.
      for (int i = 0; i < 20; i++) send(20'h7FF00, 4'd0);
      drain();
      chk("sat_sticky", sat_count, CNT_MAX);
      chk("sat_model", model_cnt, CNT_MAX);

      // Clear lands in the same cycle as a saturating S1->S2 transfer.
      send(20'h80000, 4'd0);
      sat_clr = 1'b1;
      @(posedge clk); #1;
      sat_clr = 1'b0;
      model_cnt = 0;
      chk("clr_wins", sat_count, 0);
      drain();

      // Random traffic with random backpressure.
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom % 4) != 0;
         in20      = (($urandom % 2) != 0) ? 20'($urandom) : 20'($signed($urandom_range(0, 16000)) - 8000);
         shift     = 4'($urandom);
         out_ready = ($urandom % 3) != 0;
      end
      drain();
      chk("rand_sat", sat_count, model_cnt);

      // Reset with two words in flight.
      out_ready = 1'b0;
      send(20'd5000, 4'd2);
      send(20'd6000, 4'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_sat", sat_count, 0);
      exp_q.delete();
      model_cnt = 0;
      @(negedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_out_valid", out_valid, 0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(20'd296, 4'd4);
      drain();
      chk("post_rst_sat", sat_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end
endmodule
